sramlike_resp: RTL

Memory-side responder for the CPU's SRAM-like data interface (req/addr_ok/data_ok handshake). It accepts load and store requests, queues up to DEPTH of them, and returns in-order responses after a programmable latency. It serves as the data-memory model the pipeline's memory stage and the AXI bridge are verified against.

---
 rtl/sramlike_pkg.sv | 31 +++
 rtl/sramlike_req_fifo.sv | 56 +++++
 rtl/sramlike_resp.sv | 108 ++++++++++
 3 files changed

// File: rtl/sramlike_pkg.sv
// Shared types for the SRAM-like data-memory responder.
// Holds size encodings, the byte-strobe helper and the queued request entry.
// No logic of its own; imported by the FIFO and the responder top.
package sramlike_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Word index is kept at full 30-bit width so the entry does not depend on ADDR_W.
  localparam int WIDX_W = 30;

  typedef struct packed {
    logic              wr;
    logic [3:0]        strb;
    logic [WIDX_W-1:0] widx;
    logic [31:0]       wdata;
  } reqEntry_t;

  // Byte lanes touched by an access; address bits finer than the size are ignored.
  function automatic logic [3:0] calcStrb(input logic [1:0] size, input logic [1:0] addrLo);
    logic [3:0] s;
    case (size)
      SZ_BYTE: s = 4'b0001 << addrLo;
      SZ_HALF: s = addrLo[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sramlike_req_fifo.sv
// Request queue: DEPTH-entry synchronous FIFO of reqEntry_t with occupancy count.
// Latency: pushed entry is visible on popData the cycle after the push edge.
// Backpressure: push is ignored when full, pop is ignored when empty.
module sramlike_req_fifo
  import sramlike_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  reqEntry_t        pushData,
  input  logic             pop,
  output reqEntry_t        popData,
  output logic [CNT_W-1:0] count
);

  reqEntry_t        store [DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic             doPush;
  logic             doPop;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign doPush  = push && (count < CNT_W'(DEPTH));
  assign doPop   = pop && (count != '0);
  assign popData = store[rdPtr];

  // Pointer and occupancy bookkeeping; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= nextPtr(wrPtr);
      if (doPop)  rdPtr <= nextPtr(rdPtr);
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset; only slots behind the pointers are ever read.
  always_ff @(posedge clk) begin
    if (doPush) store[wrPtr] <= pushData;
  end

endmodule

// File: rtl/sramlike_resp.sv
// SRAM-like data-memory responder: queues loads/stores, retires them in order into a word memory.
// Latency: data_ok LAT cycles after acceptance into an empty queue, then LAT apart per queued entry.
// Backpressure: addr_ok drops while DEPTH requests are outstanding. Option: SRAMLIKE_RESP_RAND_LAT_EN.
module sramlike_resp
  import sramlike_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int LAT    = 2,
  parameter int DEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int         CNT_W = $clog2(DEPTH + 1);
  localparam logic [4:0] LAT_V = 5'(LAT);

  logic [CNT_W-1:0]  qCount;
  reqEntry_t         pushEntry;
  reqEntry_t         headEntry;
  logic              accept;
  logic              retire;
  logic [4:0]        headCnt;
  logic [4:0]        loadVal;
  logic [ADDR_W-1:0] memIdx;
  logic              unusedWidx;
  logic [31:0]       mem [2**ADDR_W];

  assign addr_ok    = rst & (qCount < CNT_W'(DEPTH));
  assign accept     = req & addr_ok;
  assign retire     = (headCnt == 5'd1);
  assign data_ok    = retire;
  assign memIdx     = headEntry.widx[ADDR_W-1:0];
  assign unusedWidx = ^headEntry.widx;

  // Build the queue entry, resolving byte strobes at acceptance time.
  always_comb begin
    pushEntry       = '0;
    pushEntry.wr    = wr;
    pushEntry.strb  = calcStrb(size, addr[1:0]);
    pushEntry.widx  = addr[31:2];
    pushEntry.wdata = wdata;
  end

  sramlike_req_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst),
    .push     (accept),
    .pushData (pushEntry),
    .pop      (retire),
    .popData  (headEntry),
    .count    (qCount)
  );

`ifdef SRAMLIKE_RESP_RAND_LAT_EN
  logic [15:0] lfsr;

  // Galois LFSR for x^16+x^14+x^13+x^11+1, stepping every cycle to jitter the head latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= 16'hACE1;
    else      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  assign loadVal = LAT_V + {3'b000, lfsr[1:0]};
`else
  assign loadVal = LAT_V;
`endif

  // Head countdown: reload when a new entry reaches the head, otherwise count down to 1 (retire).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      headCnt <= '0;
    end else if (retire) begin
      // Next head is either the entry behind this one or a request accepted this very edge.
      headCnt <= ((qCount > CNT_W'(1)) || accept) ? loadVal : 5'd0;
    end else if (accept && (qCount == '0)) begin
      headCnt <= loadVal;
    end else if (headCnt != 5'd0) begin
      headCnt <= headCnt - 5'd1;
    end
  end

  // Stores commit their strobed lanes when they retire; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (retire && headEntry.wr) begin
      for (int i = 0; i < 4; i++) begin
        if (headEntry.strb[i]) mem[memIdx][8*i +: 8] <= headEntry.wdata[8*i +: 8];
      end
    end
  end

  // Loads return the pre-edge word so a retiring load never sees a later store.
  always_comb begin
    rdata = '0;
    if (retire && !headEntry.wr) rdata = mem[memIdx];
  end

endmodule
